// File: rtl/ddr4_v2_2_20_axi_dwn_pkg.sv
// ---------------------------------------------------------------------------
// ddr4_v2_2_20_axi_dwn_pkg
//   Shared definitions for the AXI write-data downsizer:
//     - dwn_state_t : control states of the W downsizer (IDLE, FETCH, SEND)
//     - CMD_LEN_W   : width of the narrow burst length field (beats minus 1)
//     - clog2_ratio : ceiling log2, used to size the narrow word index
// ---------------------------------------------------------------------------
package ddr4_v2_2_20_axi_dwn_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,   // waiting for a burst command
        FETCH = 2'd1,   // waiting for the next wide beat
        SEND  = 2'd2    // emitting narrow slices of the held wide beat
    } dwn_state_t;

    localparam int CMD_LEN_W = 8;

    function automatic int clog2_ratio(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/ddr4_v2_2_20_w_word_sel.sv
// ---------------------------------------------------------------------------
// ddr4_v2_2_20_w_word_sel
//   Combinational R:1 slice mux. Picks narrow word 'word_idx' out of a wide
//   data/strobe pair; word 0 is the least significant slice.
//   Ports:
//     wide_data   in  S_WIDTH      wide data word
//     wide_strb   in  S_WIDTH/8    wide strobes
//     word_idx    in  IDX_W        narrow slice index
//     narrow_data out M_WIDTH      selected data slice
//     narrow_strb out M_WIDTH/8    selected strobe slice
// ---------------------------------------------------------------------------
module ddr4_v2_2_20_w_word_sel #(
    parameter int S_WIDTH = 128,
    parameter int M_WIDTH = 32,
    parameter int IDX_W   = 2
) (
    input  logic [S_WIDTH-1:0]   wide_data,
    input  logic [S_WIDTH/8-1:0] wide_strb,
    input  logic [IDX_W-1:0]     word_idx,
    output logic [M_WIDTH-1:0]   narrow_data,
    output logic [M_WIDTH/8-1:0] narrow_strb
);

    always_comb begin
        narrow_data = wide_data[int'(word_idx)*M_WIDTH +: M_WIDTH];
        narrow_strb = wide_strb[int'(word_idx)*(M_WIDTH/8) +: M_WIDTH/8];
    end

endmodule

// File: rtl/ddr4_v2_2_20_w_downsizer.sv
// ---------------------------------------------------------------------------
// ddr4_v2_2_20_w_downsizer
//   AXI W-channel downsizer. A burst command (start word offset, narrow
//   length) is taken in IDLE; each wide beat is fetched, held, and replayed
//   as narrow beats. Crossing a wide-beat boundary costs one bubble cycle.
//   Every output is a flop, so M_AXI_WREADY never reaches S_AXI_WREADY
//   combinationally.
//   Ports:
//     ACLK, ARESET            clock, async active-high reset
//     cmd_valid/ready         burst command handshake
//     cmd_offset, cmd_len     first narrow word index, narrow beats minus 1
//     S_AXI_W*                wide write-data slave port
//     M_AXI_W*                narrow write-data master port
//     wlast_err               one-cycle pulse when the wide WLAST disagrees
//                             with the command length
// ---------------------------------------------------------------------------
module ddr4_v2_2_20_w_downsizer
    import ddr4_v2_2_20_axi_dwn_pkg::*;
#(
    parameter string C_FAMILY           = "virtex6",
    parameter int    C_S_AXI_DATA_WIDTH = 128,
    parameter int    C_M_AXI_DATA_WIDTH = 32,
    localparam int   RATIO              = C_S_AXI_DATA_WIDTH / C_M_AXI_DATA_WIDTH,
    localparam int   LOG_R              = clog2_ratio(RATIO)
) (
    input  logic                            ACLK,
    input  logic                            ARESET,
    input  logic                            cmd_valid,
    output logic                            cmd_ready,
    input  logic [LOG_R-1:0]                cmd_offset,
    input  logic [CMD_LEN_W-1:0]            cmd_len,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WLAST,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
    output logic                            M_AXI_WLAST,
    output logic                            M_AXI_WVALID,
    input  logic                            M_AXI_WREADY,
    output logic                            wlast_err
);

    localparam int S_W  = C_S_AXI_DATA_WIDTH;
    localparam int M_W  = C_M_AXI_DATA_WIDTH;

    // Control state
    dwn_state_t             state_q,      state_d;
    logic [LOG_R-1:0]       word_idx_q,   word_idx_d;
    logic [CMD_LEN_W-1:0]   remaining_q,  remaining_d;

    // Held wide beat
    logic [S_W-1:0]         wide_data_q,  wide_data_d;
    logic [S_W/8-1:0]       wide_strb_q,  wide_strb_d;
    logic                   wide_last_q,  wide_last_d;

    // Registered outputs
    logic                   cmd_ready_q,  cmd_ready_d;
    logic                   s_wready_q,   s_wready_d;
    logic                   m_wvalid_q,   m_wvalid_d;
    logic                   m_wlast_q,    m_wlast_d;
    logic [M_W-1:0]         m_wdata_q,    m_wdata_d;
    logic [M_W/8-1:0]       m_wstrb_q,    m_wstrb_d;
    logic                   wlast_err_q,  wlast_err_d;

    // The output slice is selected from the *next* held beat and index so
    // that the registered narrow data lines up with m_wvalid_q.
    ddr4_v2_2_20_w_word_sel #(
        .S_WIDTH (S_W),
        .M_WIDTH (M_W),
        .IDX_W   (LOG_R)
    ) u_word_sel (
        .wide_data   (wide_data_d),
        .wide_strb   (wide_strb_d),
        .word_idx    (word_idx_d),
        .narrow_data (m_wdata_d),
        .narrow_strb (m_wstrb_d)
    );

    // NOTE: every signal written here is given a default first, so no path
    // through the case leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        word_idx_d  = word_idx_q;
        remaining_d = remaining_q;
        wide_data_d = wide_data_q;
        wide_strb_d = wide_strb_q;
        wide_last_d = wide_last_q;
        wlast_err_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    word_idx_d  = cmd_offset;
                    remaining_d = cmd_len;
                    state_d     = FETCH;
                end
            end
            FETCH: begin
                if (S_AXI_WVALID) begin
                    wide_data_d = S_AXI_WDATA;
                    wide_strb_d = S_AXI_WSTRB;
                    wide_last_d = S_AXI_WLAST;
                    state_d     = SEND;
                end
            end
            SEND: begin
                if (M_AXI_WREADY) begin
                    if (remaining_q == '0) begin
                        // Burst done: the held wide beat should have been last.
                        state_d     = IDLE;
                        wlast_err_d = ~wide_last_q;
                    end else begin
                        // word_idx is LOG_R bits wide, so +1 wraps modulo R.
                        word_idx_d  = word_idx_q + 1'b1;
                        remaining_d = remaining_q - 1'b1;
                        if (word_idx_q == {LOG_R{1'b1}}) begin
                            // Wide beat exhausted mid-burst: it must not be last.
                            state_d     = FETCH;
                            wlast_err_d = wide_last_q;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        cmd_ready_d = (state_d == IDLE);
        s_wready_d  = (state_d == FETCH);
        m_wvalid_d  = (state_d == SEND);
        m_wlast_d   = (state_d == SEND) && (remaining_d == '0);
    end

    // NOTE: the held wide data register is reset along with the control
    // flops; it is a single beat of storage, not a memory array, and a known
    // value after reset keeps the narrow outputs at zero until first use.
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge values of its inputs regardless of statement order.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q     <= IDLE;
            word_idx_q  <= '0;
            remaining_q <= '0;
            wide_data_q <= '0;
            wide_strb_q <= '0;
            wide_last_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            s_wready_q  <= 1'b0;
            m_wvalid_q  <= 1'b0;
            m_wlast_q   <= 1'b0;
            m_wdata_q   <= '0;
            m_wstrb_q   <= '0;
            wlast_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            word_idx_q  <= word_idx_d;
            remaining_q <= remaining_d;
            wide_data_q <= wide_data_d;
            wide_strb_q <= wide_strb_d;
            wide_last_q <= wide_last_d;
            cmd_ready_q <= cmd_ready_d;
            s_wready_q  <= s_wready_d;
            m_wvalid_q  <= m_wvalid_d;
            m_wlast_q   <= m_wlast_d;
            m_wdata_q   <= m_wdata_d;
            m_wstrb_q   <= m_wstrb_d;
            wlast_err_q <= wlast_err_d;
        end
    end

    assign cmd_ready    = cmd_ready_q;
    assign S_AXI_WREADY = s_wready_q;
    assign M_AXI_WVALID = m_wvalid_q;
    assign M_AXI_WLAST  = m_wlast_q;
    assign M_AXI_WDATA  = m_wdata_q;
    assign M_AXI_WSTRB  = m_wstrb_q;
    assign wlast_err    = wlast_err_q;

endmodule

// File: doc/ddr4_v2_2_20_w_downsizer.md
Name: ddr4_v2_2_20_w_downsizer

Overview:
- Write-data (W channel) downsizer for the AXI interconnect in front of the DDR4 controller; the opposite direction of the W upsizer.
- Accepts one wide write beat at a time and emits it as a sequence of narrow beats, honouring a per-burst start offset and narrow burst length.
- A per-burst command, issued by the AW-side splitter, tells the block where the burst starts and how many narrow beats to emit.

Parameters:
- C_FAMILY, "virtex6", target family string; no functional effect.
- C_S_AXI_DATA_WIDTH, 128, wide (slave-side) data width in bits.
- C_M_AXI_DATA_WIDTH, 32, narrow (master-side) data width in bits.
- Legal widths: ratio R = S/M is a power of two, 2..16. Derived LOG_R = log2(R).

Ports:
- ACLK  in  1  clock.
- ARESET  in  1  reset; asynchronous, active-high; one clock domain.
- cmd_valid  in  1  burst command valid.
- cmd_ready  out  1  block idle and able to take a command.
- cmd_offset  in  LOG_R  narrow word index of the first narrow beat within the first wide beat.
- cmd_len  in  8  number of narrow beats minus 1.
- S_AXI_WDATA  in  S  wide write data.
- S_AXI_WSTRB  in  S/8  wide strobes.
- S_AXI_WLAST  in  1  wide last.
- S_AXI_WVALID  in  1  wide beat valid.
- S_AXI_WREADY  out  1  wide beat accepted.
- M_AXI_WDATA  out  M  narrow data.
- M_AXI_WSTRB  out  M/8  narrow strobes.
- M_AXI_WLAST  out  1  narrow last.
- M_AXI_WVALID  out  1  narrow beat valid.
- M_AXI_WREADY  in  1  narrow beat accepted.
- wlast_err  out  1  one-cycle pulse on wide WLAST mismatch.

Behaviour:
- Reset values: state IDLE; cmd_ready=1; S_AXI_WREADY=0; M_AXI_WVALID=0; M_AXI_WLAST=0; wlast_err=0; data/strb registers 0.
- All outputs are registered, and there is no combinational path from M_AXI_WREADY to S_AXI_WREADY.
- IDLE: cmd_ready=1. On cmd_valid, capture the command: word_idx=cmd_offset, remaining=cmd_len. Then go to FETCH.
- FETCH: S_AXI_WREADY=1. On S_AXI_WVALID, latch the wide WDATA/WSTRB/WLAST. Then go to SEND.
- Latency: a wide beat accepted in cycle t gives M_AXI_WVALID=1 in cycle t+1.
- SEND: M_AXI_WVALID=1. The outputs are:
  - WDATA = slice word_idx of the held wide beat.
  - WSTRB = strobe slice word_idx.
  - WLAST = (remaining==0).
- Outputs stay stable while M_AXI_WREADY=0.
- On acceptance (M_AXI_WREADY=1 in SEND):
  - If remaining==0: the burst is done. Go to IDLE; cmd_ready is re-asserted next cycle.
  - Else if word_idx==R-1: word_idx wraps to 0 and remaining decrements. Go to FETCH, giving one bubble cycle per wide-beat boundary.
  - Else: word_idx+1, remaining-1, stay in SEND.
- Narrow beats with all-zero strobe are still emitted; the block never skips beats.
- WLAST check, evaluated when a wide beat is released (leaving SEND):
  - Burst done and held S_WLAST=0: pulse wlast_err.
  - Burst not done and held S_WLAST=1: pulse wlast_err.
  - In both cases the narrow burst continues strictly per cmd_len.
- Wrap-around: word_idx arithmetic is modulo R. remaining never underflows.
- cmd_len=255 is legal (256 narrow beats).
- Commands presented while not IDLE are ignored (cmd_ready=0).
- Reset mid-burst: all state is cleared immediately (async). Any held wide beat and the in-flight narrow beat are discarded, with no WLAST emitted.

Decomposition:
- Package ddr4_v2_2_20_axi_dwn_pkg holds:
  - the state enum (IDLE, FETCH, SEND);
  - a clog2-style function computing LOG_R;
  - a constant for the command length width (8).
- Sub-module ddr4_v2_2_20_w_word_sel: a parameterised combinational R:1 slice mux for data plus strobes, indexed by word_idx.
- Everything else (FSM, counters, registers) lives in the top module.

Test Plan:
- R=4, cmd_offset=0, cmd_len=3; one wide beat 0x44444444_33333333_22222222_11111111, WSTRB=0xFFFF, WLAST=1, M_WREADY=1 -> narrow data 0x11111111, 0x22222222, 0x33333333, 0x44444444 on consecutive cycles; WLAST only on the 4th; wlast_err=0.
- cmd_offset=2, cmd_len=3; wide beats A (WLAST=0) then B (WLAST=1) -> narrow A[2], A[3], B[0], B[1]; one bubble cycle between A[3] and B[0]; WLAST on B[1].
- Same as the first scenario with M_WREADY pattern 1,0,0,1,0,1,1 -> each narrow beat held stable until accepted; the final sequence is unchanged; S_WREADY=0 throughout SEND.
- cmd_len=0, cmd_offset=3; wide beat with WLAST=0 -> single narrow beat of word 3 with WLAST=1; wlast_err pulses once; next cycle cmd_ready=1.
- cmd_len=7, offset 0; first wide beat with WLAST=1 -> wlast_err pulse after the 4th narrow beat; 8 narrow beats still emitted.
- ARESET asserted after 2 of 4 narrow beats -> same cycle, M_WVALID=0, S_WREADY=0, cmd_ready=1; a fresh command then works as in the first scenario.
